// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared constants for the pipeline hazard controller.
// Defines the register-index width, the FSM encodings and the stage-control output patterns.
`ifndef PIPE_HAZARD_CTRL_DEFINES
`define PIPE_HAZARD_CTRL_DEFINES
`define REGS_WIDTH     5
`define HZ_ST_RUN      2'd0
`define HZ_ST_MEM_WAIT 2'd1
`define HZ_ST_ERROR    2'd2
`endif

package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = `HZ_ST_RUN,
    ST_MEM_WAIT = `HZ_ST_MEM_WAIT,
    ST_ERROR    = `HZ_ST_ERROR
  } state_e;

  localparam int WCNT_W = 8;

  // Field order matches the bit order used when the outputs are viewed as one vector
  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE     = 8'b0000_0000;
  localparam ctrl_t CTRL_RUN      = 8'b1111_1000;
  localparam ctrl_t CTRL_FREEZE   = 8'b0000_1001;
  localparam ctrl_t CTRL_LOAD_USE = 8'b0011_1010;
  localparam ctrl_t CTRL_BRANCH   = 8'b1111_1110;

endpackage

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory wait stalls with timeout, taken-branch flushes,
// load-use bubbles and a saturating stalled-cycle counter.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_en,
  input  logic [`REGS_WIDTH-1:0]   id_rs1_address,
  input  logic [`REGS_WIDTH-1:0]   id_rs2_address,
  input  logic                     id_uses_rs1,
  input  logic                     id_uses_rs2,
  input  logic [`REGS_WIDTH-1:0]   ex_rd_address,
  input  logic                     ex_is_mem_read,
  input  logic                     ex_branch_taken,
  input  logic                     mem_req,
  input  logic                     mem_ready,
  output logic                     pc_en,
  output logic                     if_id_en,
  output logic                     id_ex_en,
  output logic                     ex_mem_en,
  output logic                     mem_wb_en,
  output logic                     if_id_flush,
  output logic                     id_ex_flush,
  output logic                     mem_wb_flush,
  output logic                     mem_timeout,
  output logic [31:0]              stall_cycles
);

  localparam logic [WCNT_W-1:0]      WAIT_MAX_C = WCNT_W'(WAIT_MAX);
  localparam logic [`REGS_WIDTH-1:0] REG_X0     = `REGS_WIDTH'(0);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic [WCNT_W-1:0]   w_wait_cnt_nxt;
  logic                r_branch_pend;
  logic                w_branch_pend_nxt;
  logic                r_lu_done;
  logic                w_lu_done_nxt;
  logic [31:0]         r_stall_cycles;
  ctrl_t               w_ctrl;
  logic                w_mem_stall;
  logic                w_branch;
  logic                w_lu_hit;
  logic                w_lu_stall;

  assign w_mem_stall = mem_req && !mem_ready;
  // A branch seen while EX was frozen is remembered and flushed once the pipe runs again
  assign w_branch    = ex_branch_taken || r_branch_pend;
  assign w_lu_hit    = ex_is_mem_read && (ex_rd_address != REG_X0) &&
                       ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
                        (id_uses_rs2 && (id_rs2_address == ex_rd_address)));
  // The bubble moves the load out of EX, so a second consecutive stall is never warranted
  assign w_lu_stall  = w_lu_hit && !r_lu_done;

  // State register and sequencing flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= {WCNT_W{1'b0}};
      r_branch_pend <= 1'b0;
      r_lu_done     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_branch_pend <= w_branch_pend_nxt;
      r_lu_done     <= w_lu_done_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt       = r_state;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_branch_pend_nxt = r_branch_pend;
    w_lu_done_nxt     = r_lu_done;
    if (cpu_en) begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            w_wait_cnt_nxt = 8'd1;
            w_state_nxt    = (WAIT_MAX_C <= 8'd1) ? ST_ERROR : ST_MEM_WAIT;
            w_lu_done_nxt  = 1'b0;
          end else if (w_branch) begin
            w_branch_pend_nxt = 1'b0;
            w_lu_done_nxt     = 1'b0;
          end else begin
            w_lu_done_nxt = w_lu_stall;
          end
        end
        ST_MEM_WAIT: begin
          w_lu_done_nxt = 1'b0;
          if (ex_branch_taken) begin
            w_branch_pend_nxt = 1'b1;
          end else begin
            w_branch_pend_nxt = r_branch_pend;
          end
          if (mem_ready) begin
            w_state_nxt    = ST_RUN;
            w_wait_cnt_nxt = {WCNT_W{1'b0}};
          end else if ((r_wait_cnt + 8'd1) >= WAIT_MAX_C) begin
            w_state_nxt    = ST_ERROR;
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 8'd1;
          end
        end
        ST_ERROR: begin
          w_state_nxt = ST_ERROR;
        end
        default: begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = {WCNT_W{1'b0}};
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // Output decode: memory stall beats branch flush, which beats load-use
  always_comb begin
    w_ctrl = CTRL_IDLE;
    if (!rst || !cpu_en) begin
      w_ctrl = CTRL_IDLE;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (w_mem_stall) begin
            w_ctrl = CTRL_FREEZE;
          end else if (w_branch) begin
            w_ctrl = CTRL_BRANCH;
          end else if (w_lu_stall) begin
            w_ctrl = CTRL_LOAD_USE;
          end else begin
            w_ctrl = CTRL_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            w_ctrl = CTRL_RUN;
          end else begin
            w_ctrl = CTRL_FREEZE;
          end
        end
        ST_ERROR: w_ctrl = CTRL_IDLE;
        default:  w_ctrl = CTRL_IDLE;
      endcase
    end
  end

  // Saturating count of enabled cycles in which the PC did not advance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= 32'd0;
    end else if (cpu_en && !w_ctrl.pc_en && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end else begin
      r_stall_cycles <= r_stall_cycles;
    end
  end

  assign pc_en        = w_ctrl.pc_en;
  assign if_id_en     = w_ctrl.if_id_en;
  assign id_ex_en     = w_ctrl.id_ex_en;
  assign ex_mem_en    = w_ctrl.ex_mem_en;
  assign mem_wb_en    = w_ctrl.mem_wb_en;
  assign if_id_flush  = w_ctrl.if_id_flush;
  assign id_ex_flush  = w_ctrl.id_ex_flush;
  assign mem_wb_flush = w_ctrl.mem_wb_flush;
  assign mem_timeout  = (r_state == ST_ERROR);
  assign stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (WAIT_MAX=4).
// Outputs are viewed as {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,mem_wb flushes}.
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  localparam logic [7:0] O_IDLE   = 8'b0000_0000;
  localparam logic [7:0] O_RUN    = 8'b1111_1000;
  localparam logic [7:0] O_FREEZE = 8'b0000_1001;
  localparam logic [7:0] O_LU     = 8'b0011_1010;
  localparam logic [7:0] O_BR     = 8'b1111_1110;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cpu_en;
  logic [`REGS_WIDTH-1:0] id_rs1_address;
  logic [`REGS_WIDTH-1:0] id_rs2_address;
  logic                   id_uses_rs1;
  logic                   id_uses_rs2;
  logic [`REGS_WIDTH-1:0] ex_rd_address;
  logic                   ex_is_mem_read;
  logic                   ex_branch_taken;
  logic                   mem_req;
  logic                   mem_ready;
  logic                   pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic                   if_id_flush, id_ex_flush, mem_wb_flush;
  logic                   mem_timeout;
  logic [31:0]            stall_cycles;
  logic [7:0]             outs;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .cpu_en(cpu_en),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .ex_is_mem_read(ex_is_mem_read),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .mem_wb_flush(mem_wb_flush),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  assign outs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, mem_wb_flush};

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr();
    cpu_en          = 1'b1;
    id_rs1_address  = 5'd0;
    id_rs2_address  = 5'd0;
    id_uses_rs1     = 1'b0;
    id_uses_rs2     = 1'b0;
    ex_rd_address   = 5'd0;
    ex_is_mem_read  = 1'b0;
    ex_branch_taken = 1'b0;
    mem_req         = 1'b0;
    mem_ready       = 1'b0;
  endtask

  initial begin
    clr();
    rst = 1'b0;
    #1;
    chk_val("rst_outs", {24'd0, outs}, {24'd0, O_IDLE});
    chk_val("rst_stall", stall_cycles, 32'd0);
    chk_val("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk_val("run_idle", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    chk_val("run_idle_stall", stall_cycles, 32'd0);

    // load-use on rs2, held for two cycles: only one bubble
    ex_is_mem_read = 1'b1; ex_rd_address = 5'd5;
    id_rs2_address = 5'd5; id_uses_rs2 = 1'b1;
    id_rs1_address = 5'd3; id_uses_rs1 = 1'b1;
    #1;
    chk_val("lu_rs2", {24'd0, outs}, {24'd0, O_LU});
    tick();
    chk_val("lu_rs2_stall", stall_cycles, 32'd1);
    #1;
    chk_val("lu_once", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    chk_val("lu_once_stall", stall_cycles, 32'd1);

    // destination x0 never stalls
    ex_rd_address = 5'd0; id_rs2_address = 5'd0;
    #1;
    chk_val("lu_x0", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    // matching source that is not read
    ex_rd_address = 5'd9; id_rs2_address = 5'd9; id_uses_rs2 = 1'b0; id_rs1_address = 5'd2;
    #1;
    chk_val("lu_unused_src", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    id_rs1_address = 5'd9;
    #1;
    chk_val("lu_rs1", {24'd0, outs}, {24'd0, O_LU});
    tick();
    chk_val("lu_rs1_stall", stall_cycles, 32'd2);
    ex_is_mem_read = 1'b0;
    tick();

    // branch coincident with load-use: flush only
    ex_is_mem_read = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk_val("br_lu", {24'd0, outs}, {24'd0, O_BR});
    tick();
    chk_val("br_lu_stall", stall_cycles, 32'd2);
    clr();
    #1;
    chk_val("br_after", {24'd0, outs}, {24'd0, O_RUN});
    tick();

    // memory wait: three frozen cycles, release on the fourth
    mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_val($sformatf("mw_freeze%0d", i), {24'd0, outs}, {24'd0, O_FREEZE});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk_val("mw_release", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    chk_val("mw_stall", stall_cycles, 32'd5);
    #1;
    chk_val("mw_req_ready", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    chk_val("mw_req_ready_stall", stall_cycles, 32'd5);
    clr();

    // branch held during a wait is flushed after release
    mem_req = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk_val("dbr_freeze0", {24'd0, outs}, {24'd0, O_FREEZE});
    tick();
    #1;
    chk_val("dbr_freeze1", {24'd0, outs}, {24'd0, O_FREEZE});
    tick();
    mem_ready = 1'b1;
    #1;
    chk_val("dbr_release", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    clr();
    #1;
    chk_val("dbr_flush", {24'd0, outs}, {24'd0, O_BR});
    tick();
    #1;
    chk_val("dbr_done", {24'd0, outs}, {24'd0, O_RUN});
    tick();
    chk_val("dbr_stall", stall_cycles, 32'd7);

    // cpu_en low: everything off, state and counters held
    cpu_en = 1'b0; mem_req = 1'b1;
    #1;
    chk_val("en_off_outs", {24'd0, outs}, {24'd0, O_IDLE});
    tick();
    tick();
    chk_val("en_off_stall", stall_cycles, 32'd7);
    cpu_en = 1'b1; mem_req = 1'b0;
    #1;
    chk_val("en_on_run", {24'd0, outs}, {24'd0, O_RUN});
    tick();

    // reset in the middle of a wait
    mem_req = 1'b1;
    tick();
    tick();
    chk_val("mid_wait_stall", stall_cycles, 32'd9);
    rst = 1'b0;
    #1;
    chk_val("mid_rst_outs", {24'd0, outs}, {24'd0, O_IDLE});
    chk_val("mid_rst_stall", stall_cycles, 32'd0);
    tick();
    mem_req = 1'b0;
    rst = 1'b1;
    #1;
    chk_val("mid_rst_run", {24'd0, outs}, {24'd0, O_RUN});
    tick();

    // timeout after four wait cycles, sticky until reset
    mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_val($sformatf("to_freeze%0d", i), {24'd0, outs}, {24'd0, O_FREEZE});
      chk_val($sformatf("to_flag%0d", i), {31'd0, mem_timeout}, 32'd0);
      tick();
    end
    chk_val("to_outs", {24'd0, outs}, {24'd0, O_IDLE});
    chk_val("to_flag", {31'd0, mem_timeout}, 32'd1);
    chk_val("to_stall", stall_cycles, 32'd4);
    mem_ready = 1'b1;
    tick();
    tick();
    chk_val("to_sticky", {31'd0, mem_timeout}, 32'd1);
    chk_val("to_sticky_outs", {24'd0, outs}, {24'd0, O_IDLE});
    chk_val("to_err_stall", stall_cycles, 32'd6);
    rst = 1'b0;
    #1;
    chk_val("to_rst_flag", {31'd0, mem_timeout}, 32'd0);
    chk_val("to_rst_stall", stall_cycles, 32'd0);
    tick();
    clr();
    rst = 1'b1;
    #1;
    chk_val("to_recover", {24'd0, outs}, {24'd0, O_RUN});
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
